// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit: eight ops applied CHUNK bits per clock across WIDTH-bit operands.
// Optional zero flag is built when LOGIC_UNIT_ZERO_FLAG_EN is defined; otherwise zero is tied low.
module logic_unit_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [CHUNK-1:0] slice;
    logic             last_chunk;

    function automatic logic [CHUNK-1:0] apply_op(
        input logic [2:0]       f,
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b
    );
        logic [CHUNK-1:0] r;
        r = '0;
        case (f)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: r = a ^ b;
            3'b011: r = ~(a | b);
            3'b100: r = ~(a & b);
            3'b101: r = ~(a ^ b);
            3'b110: r = a;
            3'b111: r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

    // The working value with the current chunk merged in; the completion edge copies this,
    // so the last chunk lands in result without an extra cycle.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        slice      = apply_op(op_q, a_q[int'(idx)*CHUNK +: CHUNK], b_q[int'(idx)*CHUNK +: CHUNK]);
        work_next  = work;
        work_next[int'(idx)*CHUNK +: CHUNK] = slice;
        last_chunk = (state == RUN) && (idx == LAST_IDX);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            work   <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        idx   <= '0;
                        op_q  <= op;
                        a_q   <= A;
                        b_q   <= B;
                        work  <= '0;
                    end
                end
                RUN: begin
                    work <= work_next;
                    if (last_chunk) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= work_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic zero_q;

    // Reset value 1 keeps the flag consistent with result being 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else if (last_chunk) begin
            zero_q <= (work_next == '0);
        end
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_serial.sv
// Self-checking bench for logic_unit_serial: directed cases plus randomized ops against a full-width reference model.
// Covers the default 32/8 configuration and a 16/16 single-cycle instance.
module tb_logic_unit_serial;

    localparam int W0 = 32;
    localparam int C0 = 8;
    localparam int N0 = W0 / C0;
    localparam int W1 = 16;
    localparam int C1 = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [W0-1:0] a = '0;
    logic [W0-1:0] b = '0;
    logic          busy;
    logic          done;
    logic [W0-1:0] result;
    logic          zero;

    logic          start1 = 1'b0;
    logic [2:0]    op1 = '0;
    logic [W1-1:0] a1 = '0;
    logic [W1-1:0] b1 = '0;
    logic          busy1;
    logic          done1;
    logic [W1-1:0] result1;
    logic          zero1;

    int n_cmp = 0;
    int n_err = 0;
    logic [W0-1:0] prev_res = '0;

    always #5 clk = ~clk;

    logic_unit_serial #(.WIDTH(W0), .CHUNK(C0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    logic_unit_serial #(.WIDTH(W1), .CHUNK(C1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .result(result1), .zero(zero1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: whole-operand bitwise function, independent of chunking.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        case (f)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x | y);
            3'd4: return ~(x & y);
            3'd5: return ~(x ^ y);
            3'd6: return x;
            default: return ~x;
        endcase
    endfunction

    function automatic logic exp_zero(input logic [31:0] r);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        return (r == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Entered at a negedge with dut idle (or in its done cycle). Drives start, then checks
    // busy/done/result-hold on each RUN cycle and the completion exactly N edges later.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input bit scramble, input bit chain);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        for (int i = 0; i < N0; i++) begin
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_hold", result, prev_res);
            start = 1'b0;
            if (scramble && i < N0 - 1) begin
                start = 1'b1;
                op    = 3'b001;
                a     = 32'hFFFF_FFFF;
                b     = $urandom;
            end
            @(negedge clk);
        end
        check("cmp_done", done, 1);
        check("cmp_busy", busy, 0);
        check("cmp_result", result, exp);
        check("cmp_zero", zero, exp_zero(exp));
        prev_res = exp;
        if (!chain) begin
            @(negedge clk);
            check("post_done", done, 0);
            check("post_busy", busy, 0);
            check("post_result", result, exp);
        end
    endtask

    task automatic run_op1(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] exp);
        start1 = 1'b1;
        op1    = o;
        a1     = x;
        b1     = y;
        @(negedge clk);
        check("n1_busy", busy1, 1);
        check("n1_early", done1, 0);
        start1 = 1'b0;
        @(negedge clk);
        check("n1_done", done1, 1);
        check("n1_result", result1, exp);
        check("n1_zero", zero1, exp_zero({16'h0, exp}));
        @(negedge clk);
        check("n1_fall", done1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [15:0] sa, sb;
        logic [31:0] full;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, exp_zero(0));
        check("rst1_result", result1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // NOR of zeros
        run_op(3'b011, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0);

        // All ops on fixed operands
        run_op(3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0, 0);
        run_op(3'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 0, 0);
        run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 0, 0);
        run_op(3'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000, 0, 0);
        run_op(3'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF0F_EDCB, 0, 0);
        run_op(3'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00FF_1234, 0, 0);
        run_op(3'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF0F0_1234, 0, 0);
        run_op(3'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0F0F_EDCB, 0, 0);

        // Inputs change and start held during RUN: latched values win, nothing queued
        run_op(3'd0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1, 0);

        // Back-to-back: second start in the done cycle
        run_op(3'd2, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'hDEAD_4110, 0, 1);
        run_op(3'd0, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 0, 0);

        // Reset two edges into a RUN
        start = 1'b1;
        op    = 3'd1;
        a     = 32'hAAAA_0000;
        b     = 32'h0000_5555;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_zero", zero, exp_zero(0));
        @(negedge clk);
        rst_n    = 1'b1;
        prev_res = '0;
        for (int i = 0; i < N0 + 2; i++) begin
            @(negedge clk);
            check("mid_rst_nodone", done, 0);
        end
        run_op(3'd1, 32'hAAAA_0000, 32'h0000_5555, 32'hAAAA_5555, 0, 0);

        // Randomized operations, some chained back-to-back
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 5) rb = ra;
            run_op(ro, ra, rb, model(ro, ra, rb), (i % 5 == 0), (i != 23) && ($urandom_range(0, 1) == 1));
        end

        // Single-chunk instance
        run_op1(3'b010, 16'hABCD, 16'hABCD, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            ro   = 3'($urandom_range(0, 7));
            sa   = 16'($urandom);
            sb   = 16'($urandom);
            full = model(ro, {16'h0, sa}, {16'h0, sb});
            run_op1(ro, sa, sb, full[15:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
